skew_feeder: RTL

Input-side feeder for the systolic array. Accepts one row of N operands per cycle over a valid/ready handshake and presents them to the array's west edge skewed in time: lane i is delayed i cycles relative to lane 0. Per-lane valid accompanies the data. A pass is framed by a last flag; the block drains the skew pipeline before accepting the next pass, then signals completion.

---
 rtl/skew_feeder.sv | 71 +++++++
 1 files changed

// File: rtl/skew_feeder.sv
// skew_feeder: skews one accepted row per cycle onto the array west edge, lane i delayed i+1 cycles.
module skew_feeder #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [N*DATA_W-1:0] in_data_i,
  input  logic                in_last_i,
  output logic [N*DATA_W-1:0] a_data_o,
  output logic [N-1:0]        a_valid_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    row_cnt_o
);
  localparam int DW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic acc;
  assign in_ready_o = state != DRAIN;
  assign busy_o     = state != IDLE;
  assign done_o     = state == DRAIN && dcnt == '0;
  assign acc        = in_valid_i && in_ready_o;
  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    if (acc) begin
      state_n = in_last_i ? DRAIN : STREAM;
      dcnt_n  = in_last_i ? DW'(N - 1) : dcnt;
    end else if (state == DRAIN) begin
      state_n = done_o ? IDLE : DRAIN;
      dcnt_n  = dcnt - 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      dcnt      <= '0;
      row_cnt_o <= '0;
    end else begin
      state <= state_n;
      dcnt  <= dcnt_n;
      if (acc)
        row_cnt_o <= state == IDLE ? CNT_W'(1) : (&row_cnt_o ? row_cnt_o : row_cnt_o + 1'b1);
    end
  end
  // bubbles enter as zero data with valid low, so invalid lanes always drive 0
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] d [i+1];
    logic [i:0] v;
    always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
        d <= '{default: '0};
        v <= '0;
      end else begin
        d[0] <= acc ? in_data_i[i*DATA_W +: DATA_W] : '0;
        v[0] <= acc;
        for (int j = 1; j <= i; j++) begin
          d[j] <= d[j-1];
          v[j] <= v[j-1];
        end
      end
    end
    assign a_data_o[i*DATA_W +: DATA_W] = d[i];
    assign a_valid_o[i] = v[i];
  end
endmodule
